pattern_seq_ctrl: RTL and testbench

//  Programmable serial pattern-detection controller. Generalises the fixed 101 Mealy/Moore detectors.

---
 rtl/pattern_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_pattern_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_seq_ctrl.sv
// Programmable serial pattern detector: latches a pattern config, scans m while running, counts matches.
// s pulses one cycle after the edge that samples the final pattern bit; cfg_ready is low only while running.
module pattern_seq_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [4:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    output logic               cfg_err,
    input  logic               start,
    input  logic               abort,
    input  logic               m,
    input  logic               m_valid,
    output logic               s,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, CONFIGURED, RUN, DONE} state_t;

    localparam logic [4:0]       MAXL    = 5'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [MAX_LEN-1:0] pat_q;
    logic [4:0]         len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;
    // Only MAX_LEN-1 past bits are needed; the incoming bit completes the window.
    logic [MAX_LEN-2:0] hist;
    logic [4:0]         bits_seen;

    logic               hs;
    logic               len_ok;
    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] mask;
    logic [4:0]         bits_n;
    logic               match;
    logic [CNT_W-1:0]   cnt_inc;

    assign cfg_ready = (state != RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    always_comb begin
        hs      = cfg_valid & cfg_ready;
        len_ok  = (cfg_len != 5'd0) && (cfg_len <= MAXL);
        hist_n  = {hist, m};
        bits_n  = (bits_seen == MAXL) ? bits_seen : bits_seen + 5'd1;
        mask    = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
        match   = (bits_n >= len_q) && ((hist_n & mask) == (pat_q & mask));
        cnt_inc = (match_count == CNT_MAX) ? match_count : match_count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            tgt_q       <= '0;
            hist        <= '0;
            bits_seen   <= '0;
            match_count <= '0;
            s           <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            s       <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs) begin
                        if (len_ok) begin
                            pat_q <= cfg_pattern;
                            len_q <= cfg_len;
                            ovl_q <= cfg_overlap;
                            tgt_q <= cfg_target;
                            state <= CONFIGURED;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                CONFIGURED, DONE: begin
                    // A config handshake takes priority over a start on the same edge.
                    if (hs) begin
                        if (len_ok) begin
                            pat_q <= cfg_pattern;
                            len_q <= cfg_len;
                            ovl_q <= cfg_overlap;
                            tgt_q <= cfg_target;
                            state <= CONFIGURED;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end else if (start) begin
                        hist        <= '0;
                        bits_seen   <= '0;
                        match_count <= '0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= CONFIGURED;
                    end else if (m_valid) begin
                        hist      <= hist_n[MAX_LEN-2:0];
                        bits_seen <= (match && !ovl_q) ? 5'd0 : bits_n;
                        s         <= match;
                        if (match) begin
                            match_count <= cnt_inc;
                            if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
                                state <= DONE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Bench for pattern_seq_ctrl: directed scenarios plus randomized runs against a bit-queue reference model.
module tb_pattern_seq_ctrl;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [4:0]         cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic [CNT_W-1:0]   cfg_target = '0;
    logic               cfg_err;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               m = 1'b0;
    logic               m_valid = 1'b0;
    logic               s;
    logic [CNT_W-1:0]   match_count;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;

    pattern_seq_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_target(cfg_target), .cfg_err(cfg_err), .start(start), .abort(abort),
        .m(m), .m_valid(m_valid), .s(s), .match_count(match_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: every valid bit since start, and how many arrived since the last counted match window.
    logic [MAX_LEN-1:0] r_pat;
    int r_len = 1, r_tgt = 0, r_cnt = 0, r_since = 0;
    bit r_ovl = 1'b0, r_done = 1'b0;
    bit r_hist[$];

    function automatic bit model_bit(input bit b);
        bit hit;
        r_hist.push_back(b);
        r_since++;
        hit = (r_since >= r_len);
        for (int j = 0; j < r_len && hit; j++)
            if (r_hist[r_hist.size() - 1 - j] != r_pat[j]) hit = 1'b0;
        if (hit) begin
            if (r_cnt < (1 << CNT_W) - 1) r_cnt++;
            if (!r_ovl) r_since = 0;
            if (r_tgt != 0 && r_cnt == r_tgt) r_done = 1'b1;
        end
        return hit;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [4:0] l, input bit o, input logic [7:0] t);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
        tick();
        cfg_valid = 1'b0;
        if (l >= 1 && l <= MAX_LEN) begin
            r_pat = p; r_len = int'(l); r_ovl = o; r_tgt = int'(t);
        end
    endtask

    task automatic arm();
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        r_hist.delete(); r_since = 0; r_cnt = 0; r_done = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic feed(input bit b, input bit v);
        @(negedge clk);
        m = b; m_valid = v;
        tick();
        m_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL reset_s got %b exp 0", s); end
        checks++; if (match_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", match_count); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b exp 0", cfg_err); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b exp 00", busy, done); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b exp 1", cfg_ready); end
    endtask

    task automatic test_overlap();
        bit st[5] = '{1, 0, 1, 0, 1};
        bit e;
        cfg(8'b101, 5'd3, 1'b1, 8'd0);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL ovl_cfg_err got %b exp 0", cfg_err); end
        arm();
        foreach (st[i]) begin
            feed(st[i], 1'b1);
            e = model_bit(st[i]);
            checks++; if (s !== e) begin errors++; $display("FAIL ovl_s bit %0d got %b exp %b", i, s, e); end
            checks++; if (match_count !== CNT_W'(r_cnt)) begin errors++; $display("FAIL ovl_count bit %0d got %0d exp %0d", i, match_count, r_cnt); end
        end
        checks++; if (match_count !== 8'd2) begin errors++; $display("FAIL ovl_final got %0d exp 2", match_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovl_busy got %b exp 1", busy); end
    endtask

    task automatic test_nonoverlap();
        bit st[5] = '{1, 0, 1, 0, 1};
        bit e;
        do_abort();
        checks++; if (busy !== 1'b0 || match_count !== 8'd2) begin errors++; $display("FAIL abort_hold got busy %b count %0d exp 0 2", busy, match_count); end
        cfg(8'b101, 5'd3, 1'b0, 8'd0);
        arm();
        checks++; if (match_count !== '0) begin errors++; $display("FAIL start_clear got %0d exp 0", match_count); end
        foreach (st[i]) begin
            feed(st[i], 1'b1);
            e = model_bit(st[i]);
            checks++; if (s !== e) begin errors++; $display("FAIL novl_s bit %0d got %b exp %b", i, s, e); end
        end
        checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL novl_final got %0d exp 1", match_count); end
    endtask

    task automatic test_target_done();
        bit st[6] = '{1, 0, 1, 1, 0, 1};
        bit e;
        do_abort();
        cfg(8'b101, 5'd3, 1'b1, 8'd2);
        arm();
        foreach (st[i]) begin
            feed(st[i], 1'b1);
            e = model_bit(st[i]);
            checks++; if (s !== e) begin errors++; $display("FAIL tgt_s bit %0d got %b exp %b", i, s, e); end
            checks++; if (done !== r_done) begin errors++; $display("FAIL tgt_done bit %0d got %b exp %b", i, done, r_done); end
        end
        checks++; if (done !== 1'b1 || cfg_ready !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL tgt_state got done %b rdy %b busy %b exp 1 1 0", done, cfg_ready, busy); end
        checks++; if (match_count !== 8'd2) begin errors++; $display("FAIL tgt_count got %0d exp 2", match_count); end
    endtask

    task automatic test_gaps();
        bit e;
        cfg(8'b101, 5'd3, 1'b1, 8'd0);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_to_cfg got done %b busy %b exp 0 0", done, busy); end
        arm();
        feed(1'b1, 1'b1); e = model_bit(1'b1);
        for (int k = 0; k < 3; k++) begin
            feed(1'($urandom_range(0, 1)), 1'b0);
            checks++; if (s !== 1'b0) begin errors++; $display("FAIL gap_s cycle %0d got %b exp 0", k, s); end
        end
        feed(1'b0, 1'b1); e = model_bit(1'b0);
        checks++; if (s !== e) begin errors++; $display("FAIL gap_mid got %b exp %b", s, e); end
        feed(1'b1, 1'b1); e = model_bit(1'b1);
        checks++; if (s !== 1'b1 || e !== 1'b1) begin errors++; $display("FAIL gap_final got %b exp 1", s); end
    endtask

    task automatic test_cfg_err();
        bit st[3] = '{1, 1, 1};
        bit e;
        rst = 1'b1; tick(); rst = 1'b0;
        cfg(8'b11, 5'd0, 1'b1, 8'd0);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_len0 got %b exp 1", cfg_err); end
        tick();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_pulse got %b exp 0", cfg_err); end
        @(negedge clk); start = 1'b1; tick(); start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_stay_idle got busy %b exp 0", busy); end
        cfg(8'b11, 5'd2, 1'b1, 8'd0);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_legal got %b exp 0", cfg_err); end
        cfg(8'b00, 5'd9, 1'b1, 8'd0);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_len9 got %b exp 1", cfg_err); end
        @(negedge clk);
        cfg_valid = 1'b1; start = 1'b1; cfg_pattern = 8'b11; cfg_len = 5'd2; cfg_overlap = 1'b1; cfg_target = 8'd0;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfg_beats_start got busy %b exp 0", busy); end
        arm();
        foreach (st[i]) begin
            feed(st[i], 1'b1);
            e = model_bit(st[i]);
            checks++; if (s !== e) begin errors++; $display("FAIL err_oldcfg_s bit %0d got %b exp %b", i, s, e); end
        end
    endtask

    task automatic test_rst_abort();
        do_abort();
        cfg(8'b101, 5'd3, 1'b1, 8'd0);
        arm();
        feed(1'b1, 1'b1);
        feed(1'b0, 1'b1);
        @(negedge clk); rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || s !== 1'b0 || cfg_err !== 1'b0 || match_count !== '0)
            begin errors++; $display("FAIL rst_run got busy %b done %b s %b err %b cnt %0d exp all 0", busy, done, s, cfg_err, match_count); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_run_rdy got %b exp 1", cfg_ready); end
        @(negedge clk); start = 1'b1; tick(); start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle got busy %b exp 0", busy); end
    endtask

    task automatic test_random();
        bit b, v, e;
        for (int r = 0; r < 12; r++) begin
            cfg(8'($urandom), 5'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)));
            if (r == 11) cfg(8'($urandom), 5'($urandom_range(5, MAX_LEN)), 1'b1, 8'd0);
            arm();
            for (int k = 0; k < 60; k++) begin
                b = 1'($urandom_range(0, 1));
                v = ($urandom_range(0, 3) != 0);
                feed(b, v);
                e = v ? model_bit(b) : 1'b0;
                checks++; if (s !== e) begin errors++; $display("FAIL rnd_s run %0d step %0d got %b exp %b", r, k, s, e); end
                checks++; if (match_count !== CNT_W'(r_cnt)) begin errors++; $display("FAIL rnd_count run %0d step %0d got %0d exp %0d", r, k, match_count, r_cnt); end
                checks++; if (done !== r_done) begin errors++; $display("FAIL rnd_done run %0d step %0d got %b exp %b", r, k, done, r_done); end
                if (r_done) break;
            end
            if (!r_done) do_abort();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_target_done();
        test_gaps();
        test_cfg_err();
        test_rst_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
